// File: rtl/disp_pkg.sv
// Shared definitions for the status-message scroller.
//   - state_e     : scroller FSM states
//   - CH_*        : character codes (0x00-0x0F are hex digits)
//   - SEG_*       : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
package disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StGap
  } state_e;

  // Character codes beyond the hex digits
  localparam logic [7:0] CH_L     = 8'h10;
  localparam logic [7:0] CH_P     = 8'h11;
  localparam logic [7:0] CH_U     = 8'h12;
  localparam logic [7:0] CH_DASH  = 8'h13;
  localparam logic [7:0] CH_BLANK = 8'h1F;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational character-code to 7-segment lookup.
//   char_code : CHAR_W-bit character code (see disp_pkg)
//   seg       : active-low segments {g,f,e,d,c,b,a}; unknown codes give blank
module seg7_char_decode
  import disp_pkg::*;
#(
  parameter int unsigned CHAR_W = 5
) (
  input  logic [CHAR_W-1:0] char_code,
  output logic [6:0]        seg
);

  logic [7:0] code;

  always_comb begin
    code = 8'(char_code);
    seg  = SEG_BLANK;
    if (code < 8'h10) begin
      seg = SEG_HEX[code[3:0]];
    end else begin
      case (code)
        CH_L:     seg = SEG_L;
        CH_P:     seg = SEG_P;
        CH_U:     seg = SEG_U;
        CH_DASH:  seg = SEG_DASH;
        CH_BLANK: seg = SEG_BLANK;
        default:  seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/disp_msg_scroller.sv
// Steps a latched status message one character per tick onto a single 7-seg digit.
// A message is played REPEAT times (0 = until msg_abort), then done pulses and the
// block returns to idle to accept the next message.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   tick_in    : 1-cycle step pulse
//   msg_valid / msg_ready : message handshake (ready only while idle)
//   msg_data   : char k at [k*CHAR_W +: CHAR_W], char 0 shown first
//   msg_len    : characters used (0 -> 1, above MSG_LEN -> MSG_LEN)
//   msg_abort  : return to idle immediately, no done
//   seg        : registered active-low segments {g,f,e,d,c,b,a}
//   char_idx   : index of the character being shown
//   busy, done : message in progress / 1-cycle pulse after the final play
//
// Build option: define SCROLL_GAP_EN to insert one blank tick period between plays.
module disp_msg_scroller
  import disp_pkg::*;
#(
  parameter int unsigned MSG_LEN = 8,
  parameter int unsigned CHAR_W  = 5,
  parameter int unsigned REPEAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick_in,
  input  logic                        msg_valid,
  output logic                        msg_ready,
  input  logic [MSG_LEN*CHAR_W-1:0]   msg_data,
  input  logic [3:0]                  msg_len,
  input  logic                        msg_abort,
  output logic [6:0]                  seg,
  output logic [$clog2(MSG_LEN)-1:0]  char_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned IdxW = $clog2(MSG_LEN);

  state_e                      state_q, state_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [IdxW-1:0]             last_q, last_d;   // index of the final character
  logic [MSG_LEN*CHAR_W-1:0]   data_q, data_d;
  logic [7:0]                  rep_q, rep_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [IdxW-1:0]             len_last;
  logic                        final_play;
  logic [CHAR_W-1:0]           chars [MSG_LEN];
  logic [6:0]                  dec_seg;

  // Clamp requested length into 1..MSG_LEN and keep it as a last-index value
  always_comb begin
    if (msg_len == 4'd0) begin
      len_last = '0;
    end else if (32'(msg_len) > MSG_LEN) begin
      len_last = IdxW'(MSG_LEN - 1);
    end else begin
      len_last = IdxW'(msg_len - 4'd1);
    end
  end

  assign final_play = (REPEAT != 0) && (32'(rep_q) == REPEAT - 1);

  always_comb begin
    for (int k = 0; k < MSG_LEN; k++) begin
      chars[k] = data_q[k*CHAR_W +: CHAR_W];
    end
  end

  seg7_char_decode #(
    .CHAR_W (CHAR_W)
  ) u_decode (
    .char_code (chars[idx_q]),
    .seg       (dec_seg)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      rep_q   <= '0;
      seg_q   <= SEG_BLANK;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
      rep_q   <= rep_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    if (msg_abort) begin
      // Abort beats any tick, end of play or same-cycle accept
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A tick in the accept cycle is ignored so char 0 gets a full period
          if (msg_valid) begin
            state_d = StShow;
            idx_d   = '0;
            rep_d   = '0;
            data_d  = msg_data;
            last_d  = len_last;
          end
        end
        StShow: begin
          if (tick_in) begin
            if (idx_q != last_q) begin
              idx_d = idx_q + 1'b1;
            end else if (final_play) begin
              state_d = StIdle;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = '0;
              if (rep_q != 8'hFF) begin
                rep_d = rep_q + 8'd1;
              end
`ifdef SCROLL_GAP_EN
              state_d = StGap;
`endif
            end
          end
        end
        StGap: begin
          if (tick_in) begin
            state_d = StShow;
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    msg_ready = (state_q == StIdle);
    busy_d    = (state_d != StIdle);
    // Blank on the abort edge itself rather than one cycle later
    seg_d     = ((state_q == StShow) && !msg_abort) ? dec_seg : SEG_BLANK;
  end

  assign seg      = seg_q;
  assign char_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_disp_msg_scroller.sv
module tb_disp_msg_scroller;

  localparam int unsigned MsgLen = 8;
  localparam int unsigned CharW  = 5;

  logic                      clk;
  logic                      rst;

  // DUT a: REPEAT = 1
  logic                      tick_in;
  logic                      msg_valid;
  logic                      msg_ready;
  logic [MsgLen*CharW-1:0]   msg_data;
  logic [3:0]                msg_len;
  logic                      msg_abort;
  logic [6:0]                seg;
  logic [2:0]                char_idx;
  logic                      busy;
  logic                      done;

  // DUT b: REPEAT = 2
  logic                      b_tick;
  logic                      b_valid;
  logic                      b_ready;
  logic [MsgLen*CharW-1:0]   b_data;
  logic [3:0]                b_len;
  logic                      b_abort;
  logic [6:0]                b_seg;
  logic [2:0]                b_idx;
  logic                      b_busy;
  logic                      b_done;

  int n_chk;
  int n_bad;
  logic done_seen;
  logic busy_seen;

  // Hand-derived active-low hex patterns {g,f,e,d,c,b,a}
  logic [6:0] hex_tab [8];

  disp_msg_scroller #(
    .MSG_LEN (MsgLen),
    .CHAR_W  (CharW),
    .REPEAT  (1)
  ) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_data  (msg_data),
    .msg_len   (msg_len),
    .msg_abort (msg_abort),
    .seg       (seg),
    .char_idx  (char_idx),
    .busy      (busy),
    .done      (done)
  );

  disp_msg_scroller #(
    .MSG_LEN (MsgLen),
    .CHAR_W  (CharW),
    .REPEAT  (2)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (b_tick),
    .msg_valid (b_valid),
    .msg_ready (b_ready),
    .msg_data  (b_data),
    .msg_len   (b_len),
    .msg_abort (b_abort),
    .seg       (b_seg),
    .char_idx  (b_idx),
    .busy      (b_busy),
    .done      (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_char(input int k, input logic [4:0] code);
    msg_data[k*CharW +: CharW] = code;
  endtask

  task automatic load_a(input logic [3:0] len, input logic with_tick);
    msg_len   = len;
    msg_valid = 1'b1;
    tick_in   = with_tick;
    @(negedge clk);
    msg_valid = 1'b0;
    tick_in   = 1'b0;
  endtask

  // One tick, then one more cycle so the registered seg has caught up
  task automatic tick_a();
    tick_in = 1'b1;
    @(negedge clk);
    tick_in   = 1'b0;
    done_seen = done;
    busy_seen = busy;
    @(negedge clk);
  endtask

  task automatic tick_b();
    b_tick = 1'b1;
    @(negedge clk);
    b_tick    = 1'b0;
    done_seen = b_done;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    b_tick = 1'b0; b_valid = 1'b0; b_data = '0; b_len = 4'd0; b_abort = 1'b0;

    // 1: reset with random inputs
    rst       = 1'b1;
    tick_in   = 1'($urandom);
    msg_valid = 1'($urandom);
    msg_abort = 1'($urandom);
    msg_len   = 4'($urandom);
    msg_data  = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_ready", 32'(msg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(char_idx), 32'd0);
    tick_in = 1'b0; msg_valid = 1'b0; msg_abort = 1'b0; msg_data = '0;
    rst = 1'b0;
    @(negedge clk);

    // 2: P A 5 5, REPEAT=1
    set_char(0, 5'h11); set_char(1, 5'h0A); set_char(2, 5'h05); set_char(3, 5'h05);
    load_a(4'd4, 1'b0);
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_ready", 32'(msg_ready), 32'd0);
    @(negedge clk);
    check("pa55_c0", 32'(seg), 32'h0C);
    tick_a();
    check("pa55_c1", 32'(seg), 32'h08);
    check("pa55_i1", 32'(char_idx), 32'd1);
    tick_a();
    check("pa55_c2", 32'(seg), 32'h12);
    tick_a();
    check("pa55_c3", 32'(seg), 32'h12);
    check("pa55_i3", 32'(char_idx), 32'd3);
    check("pa55_nodone", 32'(done_seen), 32'd0);
    tick_a();
    check("pa55_done", 32'(done_seen), 32'd1);
    check("pa55_busy_off", 32'(busy_seen), 32'd0);
    check("pa55_done_1cyc", 32'(done), 32'd0);
    check("pa55_blank", 32'(seg), 32'h7F);
    check("pa55_ready", 32'(msg_ready), 32'd1);

    // 3: tick in the accept cycle is ignored
    load_a(4'd4, 1'b1);
    check("acc_tick_i0", 32'(char_idx), 32'd0);
    @(negedge clk);
    check("acc_tick_i0b", 32'(char_idx), 32'd0);
    tick_a();
    check("acc_tick_i1", 32'(char_idx), 32'd1);
    tick_a();
    check("acc_tick_i2", 32'(char_idx), 32'd2);

    // 4: abort with simultaneous tick at char 2
    msg_abort = 1'b1;
    tick_in   = 1'b1;
    @(negedge clk);
    msg_abort = 1'b0;
    tick_in   = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(msg_ready), 32'd1);
    check("abort_seg", 32'(seg), 32'h7F);
    check("abort_idx", 32'(char_idx), 32'd0);
    @(negedge clk);
    check("abort_done2", 32'(done), 32'd0);
    check("abort_seg2", 32'(seg), 32'h7F);

    // Abort in idle blocks a same-cycle accept
    msg_valid = 1'b1;
    msg_abort = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    msg_abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_ready", 32'(msg_ready), 32'd1);

    // 5a: len=0 plays a single character ('L')
    msg_data = '0;
    set_char(0, 5'h10);
    load_a(4'd0, 1'b0);
    @(negedge clk);
    check("len0_seg", 32'(seg), 32'h47);
    tick_a();
    check("len0_done", 32'(done_seen), 32'd1);
    check("len0_blank", 32'(seg), 32'h7F);

    // 5b: len=12 clamps to 8 characters
    for (int k = 0; k < 8; k++) set_char(k, 5'(k));
    load_a(4'd12, 1'b0);
    @(negedge clk);
    check("len12_c0", 32'(seg), 32'(hex_tab[0]));
    for (int i = 1; i < 8; i++) begin
      tick_a();
      check($sformatf("len12_i%0d", i), 32'(char_idx), 32'(i));
      check($sformatf("len12_c%0d", i), 32'(seg), 32'(hex_tab[i]));
      check($sformatf("len12_nd%0d", i), 32'(done_seen), 32'd0);
    end
    tick_a();
    check("len12_done", 32'(done_seen), 32'd1);
    check("len12_idx0", 32'(char_idx), 32'd0);

    // Unknown code, '-' and 'U'
    msg_data = '0;
    set_char(0, 5'h15); set_char(1, 5'h13); set_char(2, 5'h12);
    load_a(4'd3, 1'b0);
    @(negedge clk);
    check("unk_blank", 32'(seg), 32'h7F);
    check("unk_busy", 32'(busy), 32'd1);
    tick_a();
    check("dash_seg", 32'(seg), 32'h3F);
    tick_a();
    check("u_seg", 32'(seg), 32'h41);

    // Reset mid-message discards it
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_ready", 32'(msg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 6: REPEAT=2, len=2 (chars '1','2')
    b_data[0 +: CharW]     = 5'h01;
    b_data[CharW +: CharW] = 5'h02;
    b_len   = 4'd2;
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    check("rep_p1c0", 32'(b_seg), 32'h79);
    tick_b();
    check("rep_p1c1", 32'(b_seg), 32'h24);
    tick_b();
    check("rep_wrap_nodone", 32'(done_seen), 32'd0);
    check("rep_wrap_idx", 32'(b_idx), 32'd0);
`ifdef SCROLL_GAP_EN
    check("rep_gap_blank", 32'(b_seg), 32'h7F);
    check("rep_gap_busy", 32'(b_busy), 32'd1);
    tick_b();
`endif
    check("rep_p2c0", 32'(b_seg), 32'h79);
    tick_b();
    check("rep_p2c1", 32'(b_seg), 32'h24);
    tick_b();
    check("rep_done", 32'(done_seen), 32'd1);
    check("rep_blank", 32'(b_seg), 32'h7F);
    check("rep_busy", 32'(b_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
